// File: rtl/debounce_pkg_amisha.sv
// Shared debounce types: per-channel FSM state
// encoding and default tick-counter width.
package debounce_pkg_amisha;

  localparam int N_DEF = 19;
  localparam int W_DEF = 2;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } state_t;

  // Debounced level is high in ONE and while
  // waiting to confirm a release.
  function automatic logic is_high(state_t s);
    return (s == ONE) || (s == WAIT0_1) ||
           (s == WAIT0_2) || (s == WAIT0_3);
  endfunction

endpackage

// File: rtl/debounce_chan_amisha.sv
// One debounce channel: 2-flop sync, 8-state FSM,
// registered level and rising-edge tick outputs.
// Ports: clk, rst_n, m_tick, btn -> db_level, db_tick
module debounce_chan_amisha
  import debounce_pkg_amisha::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic m_tick,
  input  logic btn,
  output logic db_level,
  output logic db_tick
);

  logic [1:0] sync_q;
  logic       sync;
  state_t     state_q;
  state_t     state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign sync = sync_q[1];

  // A level reversal is checked before m_tick,
  // so it always wins over an advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO: begin
        if (sync) state_d = WAIT1_1;
      end
      WAIT1_1: begin
        if (!sync)       state_d = ZERO;
        else if (m_tick) state_d = WAIT1_2;
      end
      WAIT1_2: begin
        if (!sync)       state_d = ZERO;
        else if (m_tick) state_d = WAIT1_3;
      end
      WAIT1_3: begin
        if (!sync)       state_d = ZERO;
        else if (m_tick) state_d = ONE;
      end
      ONE: begin
        if (!sync) state_d = WAIT0_1;
      end
      WAIT0_1: begin
        if (sync)        state_d = ONE;
        else if (m_tick) state_d = WAIT0_2;
      end
      WAIT0_2: begin
        if (sync)        state_d = ONE;
        else if (m_tick) state_d = WAIT0_3;
      end
      WAIT0_3: begin
        if (sync)        state_d = ONE;
        else if (m_tick) state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase
  end

  // Outputs are computed from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ZERO;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_level <= is_high(state_d);
      db_tick  <= (state_q == WAIT1_3) &&
                  (state_d == ONE);
    end
  end

endmodule

// File: rtl/debounce_fsm_amisha.sv
// Multi-channel button debouncer top: shared
// sampling-tick counter plus W channel FSMs.
// Ports: clk_amisha, reset_amisha (async, low),
// btn_amisha[W] -> db_level_amisha, db_tick_amisha
module debounce_fsm_amisha
  import debounce_pkg_amisha::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic [W-1:0] btn_amisha,
  output logic [W-1:0] db_level_amisha,
  output logic [W-1:0] db_tick_amisha
);

  logic [N-1:0] cnt_q;
  logic         m_tick;

  always_ff @(posedge clk_amisha or
              negedge reset_amisha) begin
    if (!reset_amisha) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign m_tick = &cnt_q;

  for (genvar i = 0; i < W; i++) begin : g_chan
    debounce_chan_amisha u_chan (
      .clk      (clk_amisha),
      .rst_n    (reset_amisha),
      .m_tick   (m_tick),
      .btn      (btn_amisha[i]),
      .db_level (db_level_amisha[i]),
      .db_tick  (db_tick_amisha[i])
    );
  end

endmodule
